// File: rtl/seg_display_if.sv
// Display controller bus: value/mode inputs and the multiplexed
// active-low segment and anode outputs.
interface seg_display_if;
    logic        mod;
    logic [31:0] data;
    logic [7:0]  SEG;
    logic [7:0]  AN;

    // Driver of the value to show; observer of the display pins
    modport master (output mod, output data, input SEG, input AN);
    // The display controller itself
    modport slave  (input mod, input data, output SEG, output AN);
endinterface

// File: rtl/seg_display_ctrl.sv
// Eight-digit multiplexed 7-segment display controller.
// Hex values are written straight into the digit register; decimal values
// go through a 32-step double-dabble conversion first. Scanning runs
// independently and always shows the current digit-register contents.
module seg_display_ctrl #(
    parameter int SCAN_DIV = 100000
) (
    input  logic          clk,
    input  logic          clr,
    seg_display_if.slave  bus
);

    localparam int                CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [31:0]        shift_reg;
    logic [39:0]        bcd_reg;
    logic [39:0]        bcd_adj;
    logic [39:0]        bcd_next;
    logic [4:0]         iter_reg;
    logic [31:0]        digit_reg;
    logic               dec_mode_reg;

    logic [CNT_W-1:0]   scan_cnt_reg;
    logic [2:0]         digit_idx_reg;
    logic [7:0]         seg_reg;
    logic [7:0]         an_reg;

    logic               scan_wrap;
    logic [7:0]         blank;
    logic [3:0]         cur_nib;
    logic [7:0]         seg_next;
    logic [7:0]         an_next;

    // Active-low segment pattern {dp,g,f,e,d,c,b,a}; dp is always off
    function automatic logic [7:0] seg_encode(input logic [3:0] nib);
        logic [7:0] s;
        case (nib)
            4'h0:    s = 8'hC0;
            4'h1:    s = 8'hF9;
            4'h2:    s = 8'hA4;
            4'h3:    s = 8'hB0;
            4'h4:    s = 8'h99;
            4'h5:    s = 8'h92;
            4'h6:    s = 8'h82;
            4'h7:    s = 8'hF8;
            4'h8:    s = 8'h80;
            4'h9:    s = 8'h90;
            4'hA:    s = 8'h88;
            4'hB:    s = 8'h83;
            4'hC:    s = 8'hC6;
            4'hD:    s = 8'hA1;
            4'hE:    s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift
    generate
        for (genvar gi = 0; gi < 10; gi++) begin : g_bcd_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                        bcd_reg[gi*4 +: 4] + 4'd3 :
                                        bcd_reg[gi*4 +: 4];
        end
    endgenerate

    // The top accumulator bit can never be set for a 32-bit input, so the
    // shift simply drops it
    assign bcd_next = (bcd_adj << 1) | {39'd0, shift_reg[31]};

    // FSM state register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state: hex stays in IDLE, decimal runs 32 CONV steps then LOAD
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (!bus.mod) state_next = CONV;
            CONV:    if (iter_reg == 5'd31) state_next = LOAD;
            LOAD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Conversion datapath and digit register; only IDLE looks at the inputs
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            shift_reg    <= '0;
            bcd_reg      <= '0;
            iter_reg     <= '0;
            digit_reg    <= '0;
            dec_mode_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.mod) begin
                        digit_reg    <= bus.data;
                        dec_mode_reg <= 1'b0;
                    end else begin
                        shift_reg <= bus.data;
                        bcd_reg   <= '0;
                        iter_reg  <= '0;
                    end
                end
                CONV: begin
                    bcd_reg   <= bcd_next;
                    shift_reg <= {shift_reg[30:0], 1'b0};
                    if (iter_reg != 5'd31) begin
                        iter_reg <= iter_reg + 5'd1;
                    end
                end
                LOAD: begin
                    digit_reg    <= bcd_reg[31:0];
                    dec_mode_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Leading-zero blanking: digit k is blank when it and every digit
    // above it are zero; the rightmost digit always shows
    assign blank[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < 8; gi++) begin : g_blank
            assign blank[gi] = dec_mode_reg && (digit_reg[31:gi*4] == '0);
        end
    endgenerate

    assign scan_wrap = (scan_cnt_reg == CNT_MAX);
    assign cur_nib   = digit_reg[{digit_idx_reg, 2'b00} +: 4];
    assign seg_next  = blank[digit_idx_reg] ? 8'hFF : seg_encode(cur_nib);
    assign an_next   = ~(8'd1 << digit_idx_reg);

    // Scan timing and registered display outputs
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            scan_cnt_reg  <= '0;
            digit_idx_reg <= '0;
            seg_reg       <= 8'hFF;
            an_reg        <= 8'hFF;
        end else begin
            scan_cnt_reg <= scan_wrap ? '0 : scan_cnt_reg + 1'b1;
            if (scan_wrap) begin
                digit_idx_reg <= digit_idx_reg + 3'd1;
            end
            seg_reg <= seg_next;
            an_reg  <= an_next;
        end
    end

    assign bus.SEG = seg_reg;
    assign bus.AN  = an_reg;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Testbench for seg_display_ctrl: directed scenarios plus random values,
// checked against an arithmetic model of what each digit must show.
module tb_seg_display_ctrl;

    localparam int SCAN_DIV = 4;

    logic clk = 1'b0;
    logic clr;
    int   vec_cnt = 0;
    int   err_cnt = 0;
    int   edge_n;

    logic [7:0]  seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Model of what the display should currently hold
    logic [31:0]     disp_val;
    bit              disp_dec;
    longint unsigned disp_num;

    seg_display_if bus();

    seg_display_ctrl #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Edges since the last reset release
    always @(posedge clk or posedge clr) begin
        if (clr) edge_n <= 0;
        else     edge_n <= edge_n + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic longint unsigned pow10(input int k);
        longint unsigned p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        return p;
    endfunction

    // Digit-register contents expected after a write of d in the given mode
    function automatic logic [31:0] model_digits(input logic [31:0] d, input bit dec);
        longint unsigned v;
        logic [31:0]     r;
        if (!dec) return d;
        v = longint'(d) % 100000000;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            r[k*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic set_model(input logic [31:0] d, input bit dec);
        disp_val = model_digits(d, dec);
        disp_dec = dec;
        disp_num = longint'(d) % 100000000;
    endtask

    function automatic logic [7:0] model_seg(input int k);
        if (disp_dec && k > 0 && disp_num < pow10(k)) return 8'hFF;
        return seg_tab[disp_val[k*4 +: 4]];
    endfunction

    // One full scan cycle: AN position from elapsed edges, SEG from the model
    task automatic scan_check(input string tag);
        int         idx;
        logic [7:0] an_exp;
        for (int c = 0; c < 8 * SCAN_DIV; c++) begin
            @(negedge clk);
            idx    = ((edge_n - 1) / SCAN_DIV) % 8;
            an_exp = 8'hFF;
            an_exp[idx] = 1'b0;
            check_val({tag, "_an"}, {24'd0, bus.AN}, {24'd0, an_exp});
            check_val({tag, "_seg"}, {24'd0, bus.SEG}, {24'd0, model_seg(idx)});
        end
    endtask

    task automatic apply_and_scan(input bit m, input logic [31:0] d);
        @(negedge clk);
        bus.mod  = m;
        bus.data = d;
        repeat (80) @(negedge clk);
        set_model(d, !m);
        scan_check("scan");
        $display("txn mod=%0d data=%h digits=%h", m, d, disp_val);
    endtask

    initial begin
        logic [31:0] tbl_data [6] = '{32'h00000010, 32'h00000010, 32'h00000000,
                                      32'hFFFFFFFF, 32'hFFFFFFFF, 32'd12345678};
        bit          tbl_mod  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset state
        clr      = 1'b1;
        bus.mod  = 1'b1;
        bus.data = 32'h1234ABCD;
        #12;
        check_val("rst_seg", {24'd0, bus.SEG}, 32'hFF);
        check_val("rst_an", {24'd0, bus.AN}, 32'hFF);
        check_val("rst_digits", dut.digit_reg, 32'd0);
        $display("txn reset");

        // First edge after release: digit 0 of the cleared register
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        check_val("rel_an", {24'd0, bus.AN}, 32'hFE);
        check_val("rel_seg", {24'd0, bus.SEG}, {24'd0, seg_tab[0]});
        set_model(32'h1234ABCD, 1'b0);
        scan_check("hex_scan");
        $display("txn hex 1234ABCD scan");

        // Decimal latency: update lands on the 34th edge counting the sample edge
        @(negedge clk);
        bus.mod  = 1'b0;
        bus.data = 32'd12345678;
        repeat (33) @(negedge clk);
        check_val("lat33", dut.digit_reg, 32'h1234ABCD);
        @(negedge clk);
        check_val("lat34", dut.digit_reg, model_digits(32'd12345678, 1'b1));
        $display("txn dec latency 12345678");

        // Input change mid-conversion is ignored until the next sample
        @(negedge clk);
        bus.mod  = 1'b1;
        bus.data = 32'd0;
        repeat (40) @(negedge clk);
        bus.mod  = 1'b0;
        bus.data = 32'd100;
        repeat (11) @(negedge clk);
        bus.data = 32'd200;
        repeat (23) @(negedge clk);
        check_val("chg_first", dut.digit_reg, model_digits(32'd100, 1'b1));
        repeat (33) @(negedge clk);
        check_val("chg_hold", dut.digit_reg, model_digits(32'd100, 1'b1));
        @(negedge clk);
        check_val("chg_second", dut.digit_reg, model_digits(32'd200, 1'b1));
        $display("txn dec 100 then 200");

        // Reset mid-conversion
        @(negedge clk);
        bus.mod  = 1'b1;
        bus.data = 32'hCAFE0000;
        repeat (40) @(negedge clk);
        bus.mod  = 1'b0;
        bus.data = 32'd99;
        repeat (21) @(negedge clk);
        #2 clr = 1'b1;
        #1;
        check_val("mid_seg", {24'd0, bus.SEG}, 32'hFF);
        check_val("mid_an", {24'd0, bus.AN}, 32'hFF);
        check_val("mid_digits", dut.digit_reg, 32'd0);
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        check_val("mid_rel_an", {24'd0, bus.AN}, 32'hFE);
        check_val("mid_rel_seg", {24'd0, bus.SEG}, {24'd0, seg_tab[0]});
        repeat (40) @(negedge clk);
        set_model(32'd99, 1'b1);
        scan_check("mid_scan");
        $display("txn reset during conversion");

        // Directed boundary values, then random ones
        for (int t = 0; t < 6; t++) apply_and_scan(tbl_mod[t], tbl_data[t]);
        for (int t = 0; t < 6; t++) apply_and_scan(1'($urandom % 2), $urandom);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
